// File: rtl/gigatron_pkg.sv
// Shared decode enumerations and constants for Gigatron-family cores.
package gigatron_pkg;

  typedef enum logic [2:0] {
    OP_LD, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_ST, OP_BCC
  } op_e;

  typedef enum logic [2:0] {
    M_AC_D, M_AC_X, M_AC_YD, M_AC_YX, M_X_D, M_Y_D, M_OUT_D, M_OUT_YXI
  } mode_e;

  typedef enum logic [2:0] {
    BR_JMP, BR_GT, BR_LT, BR_NE, BR_EQ, BR_GE, BR_LE, BR_BRA
  } cond_e;

  typedef enum logic [1:0] {
    BUS_D, BUS_RAM, BUS_AC, BUS_IN
  } bus_e;

  typedef enum logic {
    DBG_RUN, DBG_HALT
  } dbg_e;

  localparam logic [15:0]  NOP         = 16'h0200;
  localparam logic [7:0]   ZAC_BIAS    = 8'h80;
  // A zero bank field in ctrl selects this bank for the upper half.
  localparam int unsigned  BANK0_ALIAS = 1;

endpackage

// File: rtl/gigatron_alu.sv
// Combinational bus mux, 8-bit ALU and branch condition evaluation.
module gigatron_alu
  import gigatron_pkg::*;
(
  input  logic [2:0] op,
  input  logic [2:0] mode,
  input  logic [1:0] bus,
  input  logic [7:0] d,
  input  logic [7:0] ac,
  input  logic [7:0] data_i,
  input  logic [7:0] inreg,
  output logic [7:0] b,
  output logic [7:0] res,
  output logic       taken
);

  logic [7:0] zac;

  always_comb begin
    b     = '0;
    res   = '0;
    taken = 1'b0;
    zac   = {~ac[7], ac[6:0]};

    case (bus_e'(bus))
      BUS_D:   b = d;
      BUS_RAM: b = data_i;
      BUS_AC:  b = ac;
      default: b = inreg;
    endcase

    case (op_e'(op))
      OP_AND:  res = ac & b;
      OP_OR:   res = ac | b;
      OP_XOR:  res = ac ^ b;
      OP_ADD:  res = ac + b;
      OP_SUB:  res = ac - b;
      default: res = b;
    endcase

    // Biasing the sign bit turns signed compares against zero into unsigned ones.
    case (cond_e'(mode))
      BR_GT:   taken = zac >  ZAC_BIAS;
      BR_LT:   taken = zac <  ZAC_BIAS;
      BR_NE:   taken = zac != ZAC_BIAS;
      BR_EQ:   taken = zac == ZAC_BIAS;
      BR_GE:   taken = zac >= ZAC_BIAS;
      BR_LE:   taken = zac <= ZAC_BIAS;
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/gigatron_core_ext.sv
// Gigatron core with upper-half RAM banking and fetch/data wait states.
// Optional GIGATRON_DEBUG_EN adds halt/step single-stepping control.
module gigatron_core_ext
  import gigatron_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     BANK_W   = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                rst_n,
`ifdef GIGATRON_DEBUG_EN
  input  logic                halt,
  input  logic                step,
`endif
  output logic [PC_W-1:0]     pc,
  input  logic [15:0]         rom_i,
  input  logic                rom_ready,
  output logic [15+BANK_W-1:0] addr_r,
  input  logic                mem_ready,
  input  logic [7:0]          data_i,
  output logic [15+BANK_W-1:0] addr_w,
  output logic [7:0]          data_o,
  output logic                we,
  input  logic [7:0]          inreg,
  output logic [7:0]          out,
  output logic [7:0]          outx,
  output logic [7:0]          ctrl
);

  localparam int unsigned AW = 15 + BANK_W;

  logic [15:0]     ir;
  logic [7:0]      ac, x, y;
  op_e             op;
  mode_e           mode;
  bus_e            bus;
  logic [7:0]      d;
  logic [7:0]      b, alu;
  logic            taken, stall, exec;
  logic [15:0]     la;
  logic [AW-1:0]   pa;
  logic [PC_W-9:0] hi;

  assign op   = op_e'(ir[15:13]);
  assign mode = mode_e'(ir[12:10]);
  assign bus  = bus_e'(ir[9:8]);
  assign d    = ir[7:0];

  gigatron_alu u_alu (
    .op     (ir[15:13]),
    .mode   (ir[12:10]),
    .bus    (ir[9:8]),
    .d      (d),
    .ac     (ac),
    .data_i (data_i),
    .inreg  (inreg),
    .b      (b),
    .res    (alu),
    .taken  (taken)
  );

  always_comb begin
    la = {8'h00, d};
    if (op != OP_BCC) begin
      case (mode)
        M_AC_X:             la = {8'h00, x};
        M_AC_YD:            la = {y, d};
        M_AC_YX, M_OUT_YXI: la = {y, x};
        default:            ;
      endcase
    end
  end

  generate
    if (BANK_W > 0) begin : g_bank
      logic [BANK_W-1:0] field, bank;
      always_comb begin
        field = ctrl[7 -: BANK_W];
        bank  = (field == '0) ? BANK_W'(BANK0_ALIAS) : field;
        pa    = la[15] ? {bank, la[14:0]} : {{BANK_W{1'b0}}, la[14:0]};
      end
    end else begin : g_flat
      assign pa = la[14:0];
    end
  endgenerate

  assign addr_r = pa;
  assign stall  = !rom_ready || ((op != OP_ST) && (bus == BUS_RAM) && !mem_ready);
  assign hi     = (cond_e'(ir[12:10]) == BR_JMP) ? (PC_W-8)'(y) : pc[PC_W-1:8];

`ifdef GIGATRON_DEBUG_EN
  dbg_e dbg_state, dbg_next;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) dbg_state <= DBG_RUN;
    else        dbg_state <= dbg_next;
  end

  // Halting takes effect in the cycle halt is seen; no instruction retires then.
  always_comb begin
    dbg_next = dbg_state;
    exec     = 1'b0;
    case (dbg_state)
      DBG_RUN: begin
        if (halt) begin
          if (!stall) dbg_next = DBG_HALT;
        end else begin
          exec = !stall;
        end
      end
      default: begin
        if (!halt) dbg_next = DBG_RUN;
        else       exec     = step && !stall;
      end
    endcase
  end
`else
  assign exec = !stall;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      ir     <= NOP;
      ac     <= '0;
      x      <= '0;
      y      <= '0;
      out    <= '0;
      outx   <= '0;
      ctrl   <= '0;
      we     <= 1'b0;
      addr_w <= '0;
      data_o <= '0;
    end else begin
      we <= 1'b0;
      if (exec) begin
        ir <= rom_i;
        pc <= pc + PC_W'(1);
        case (op)
          OP_ST: begin
            addr_w <= pa;
            data_o <= b;
            we     <= (bus != BUS_RAM);
            if (bus == BUS_RAM) ctrl <= d;
            case (mode)
              M_X_D:     x <= b;
              M_Y_D:     y <= b;
              M_OUT_YXI: x <= x + 8'd1;
              default:   ;
            endcase
          end
          OP_BCC: if (taken) pc <= {hi, b};
          default: begin
            case (mode)
              M_X_D: x <= alu;
              M_Y_D: y <= alu;
              M_OUT_D, M_OUT_YXI: begin
                out <= alu;
                if (!out[6] && alu[6]) outx <= ac;
                if (mode == M_OUT_YXI && bus == BUS_RAM) x <= x + 8'd1;
              end
              default: ac <= alu;
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gigatron_core_ext.sv
// Directed program bench for gigatron_core_ext; RAM writes and out/outx
// changes are checked against queues filled while the program is loaded.
module tb_gigatron_core_ext;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [15:0] pc, rom_i;
  logic        rom_ready, mem_ready, we;
  logic [16:0] addr_r, addr_w;
  logic [7:0]  data_i, data_o, inreg, out, outx, ctrl;
`ifdef GIGATRON_DEBUG_EN
  logic        halt, step;
`endif

  logic [15:0] rom [0:255];
  logic [24:0] wq[$];
  logic [15:0] oq[$];
  logic [7:0]  prev_out;
  bit          mon_en;
  int          total = 0;
  int          bad   = 0;

  always #5 clock = ~clock;

  assign rom_i = rom_ready ? rom[pc[7:0]] : 16'hFFFF;

  gigatron_core_ext #(
    .PC_W     (16),
    .BANK_W   (2),
    .RESET_PC (16'h0000)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
`ifdef GIGATRON_DEBUG_EN
    .halt      (halt),
    .step      (step),
`endif
    .pc        (pc),
    .rom_i     (rom_i),
    .rom_ready (rom_ready),
    .addr_r    (addr_r),
    .mem_ready (mem_ready),
    .data_i    (data_i),
    .addr_w    (addr_w),
    .data_o    (data_o),
    .we        (we),
    .inreg     (inreg),
    .out       (out),
    .outx      (outx),
    .ctrl      (ctrl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int a, input logic [15:0] w);
    rom[a] = w;
  endtask

  task automatic put_st(input int a, input logic [15:0] w, input logic [16:0] ea, input logic [7:0] ed);
    rom[a] = w;
    wq.push_back({ea, ed});
  endtask

  task automatic put_out(input int a, input logic [7:0] eo, input logic [7:0] eox);
    rom[a] = 16'h1A00;
    oq.push_back({eo, eox});
  endtask

  task automatic tick();
    logic [24:0] ew;
    logic [15:0] eo;
    @(posedge clock);
    #1;
    if (mon_en && we === 1'b1) begin
      ew = (wq.size() > 0) ? wq.pop_front() : '1;
      chk("ram_write", 32'({addr_w, data_o}), 32'(ew));
    end
    if (mon_en && out !== prev_out) begin
      prev_out = out;
      eo = (oq.size() > 0) ? oq.pop_front() : '1;
      chk("out_outx", 32'({out, outx}), 32'(eo));
    end
  endtask

  task automatic wait_pc(input logic [15:0] target, input string tag);
    int n = 0;
    while (pc !== target && n < 400) begin
      tick();
      n++;
    end
    chk(tag, 32'(pc), 32'(target));
  endtask

  initial begin
    rst_n     = 1'b0;
    rom_ready = 1'b1;
    mem_ready = 1'b1;
    data_i    = 8'hC3;
    inreg     = 8'h3C;
    mon_en    = 1'b0;
    prev_out  = 8'h00;
`ifdef GIGATRON_DEBUG_EN
    halt = 1'b0;
    step = 1'b0;
`endif
    foreach (rom[i]) rom[i] = 16'h0200;

    put   (8'h00, 16'h00AB);                        // ld $AB
    put_st(8'h01, 16'hC210, 17'h00010, 8'hAB);      // st [$10]
    put   (8'h02, 16'h0005);                        // ld $05
    put   (8'h03, 16'hEC10);                        // bne $10
    put   (8'h04, 16'h0077);                        // delay slot: ld $77
    put   (8'h05, 16'h00EE);                        // must be skipped
    put_st(8'h10, 16'hC211, 17'h00011, 8'h77);
    put   (8'h11, 16'hC100);                        // ctrl <- $00
    put   (8'h12, 16'h1481);                        // y <- $81
    put_st(8'h13, 16'hCA23, 17'h08123, 8'h77);      // bank field 0 -> bank 1
    put   (8'h14, 16'hC1C0);                        // ctrl <- $C0
    put_st(8'h15, 16'hCA23, 17'h18123, 8'h77);      // bank 3
    put   (8'h16, 16'h1401);                        // y <- $01
    put_st(8'h17, 16'hCA23, 17'h00123, 8'h77);      // lower half unbanked
    put   (8'h18, 16'h1030);                        // x <- $30
    put   (8'h19, 16'h0500);                        // ld [x]
    put_st(8'h1A, 16'hC212, 17'h00012, 8'h5A);
    put   (8'h1B, 16'h0040);
    put_out(8'h1C, 8'h40, 8'h40);
    put   (8'h1D, 16'h0041);
    put_out(8'h1E, 8'h41, 8'h40);
    put   (8'h1F, 16'h0000);
    put_out(8'h20, 8'h00, 8'h40);
    put   (8'h21, 16'h00C5);
    put_out(8'h22, 8'hC5, 8'hC5);
    put   (8'h23, 16'hA0C6);                        // sub $C6
    put_st(8'h24, 16'hC213, 17'h00013, 8'hFF);
    put   (8'h25, 16'h8002);                        // add $02
    put_st(8'h26, 16'hC214, 17'h00014, 8'h01);
    put   (8'h27, 16'h60F0);                        // xor $F0
    put_st(8'h28, 16'hC215, 17'h00015, 8'hF1);
    put   (8'h29, 16'h2055);                        // and $55
    put_st(8'h2A, 16'hC216, 17'h00016, 8'h51);
    put   (8'h2B, 16'h40A0);                        // or $A0
    put_st(8'h2C, 16'hC217, 17'h00017, 8'hF1);
    put   (8'h2D, 16'h0080);
    put   (8'h2E, 16'hE840);                        // blt $40
    put   (8'h2F, 16'h0033);                        // delay slot
    put   (8'h30, 16'h00EE);                        // must be skipped
    put   (8'h40, 16'hF050);                        // beq $50, not taken
    put_st(8'h41, 16'hC218, 17'h00018, 8'h33);
    put   (8'h42, 16'h1020);                        // x <- $20
    put   (8'h43, 16'h1400);                        // y <- $00
    put_st(8'h44, 16'hDE00, 17'h00020, 8'h33);      // st [y,x++]
    put_st(8'h45, 16'hDE00, 17'h00021, 8'h33);
    put_st(8'h46, 16'hCE00, 17'h00022, 8'h33);      // st [y,x]
    put   (8'h60, 16'hFC60);                        // bra $60

    repeat (3) @(posedge clock);
    #1;
    chk("reset_pc", 32'(pc), 32'h0);
    chk("reset_out", 32'(out), 32'h0);
    chk("reset_outx", 32'(outx), 32'h0);
    chk("reset_ctrl", 32'(ctrl), 32'h0);
    chk("reset_we", 32'(we), 32'h0);
    chk("reset_addr_w", 32'(addr_w), 32'h0);
    chk("reset_data_o", 32'(data_o), 32'h0);

    @(negedge clock);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();
    chk("pc_after_nop", 32'(pc), 32'h1);

    wait_pc(16'h001A, "reach_ld_x");
    chk("addr_r_x", 32'(addr_r), 32'h30);
    chk("ctrl_bank", 32'(ctrl), 32'hC0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mem_stall_pc", 32'(pc), 32'h1A);
      chk("mem_stall_we", 32'(we), 32'h0);
    end
    mem_ready = 1'b1;
    data_i    = 8'h5A;
    tick();
    data_i    = 8'hC3;
    chk("pc_after_mem", 32'(pc), 32'h1B);

    wait_pc(16'h0024, "reach_sub");
    rom_ready = 1'b0;
    repeat (2) begin
      tick();
      chk("rom_stall_pc", 32'(pc), 32'h24);
    end
    rom_ready = 1'b1;

`ifdef GIGATRON_DEBUG_EN
    begin : dbg
      logic [15:0] p;
      wait_pc(16'h0048, "reach_nops");
      halt = 1'b1;
      tick();
      p = pc;
      tick();
      chk("halt_holds", 32'(pc), 32'(p));
      step = 1'b1; tick(); step = 1'b0; tick();
      step = 1'b1; tick(); step = 1'b0; tick();
      chk("two_steps", 32'(pc), 32'(p + 16'd2));
      halt = 1'b0;
      repeat (3) tick();
      chk("resumed", 32'(pc > p + 16'd2), 32'h1);
    end
`endif

    wait_pc(16'h0060, "reach_loop");
    chk("writes_drained", 32'(wq.size()), 32'h0);
    chk("outs_drained", 32'(oq.size()), 32'h0);

    mon_en    = 1'b0;
    rom_ready = 1'b0;
    mem_ready = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midstall_reset_pc", 32'(pc), 32'h0);
    chk("midstall_reset_we", 32'(we), 32'h0);
    chk("midstall_reset_addr_w", 32'(addr_w), 32'h0);
    chk("midstall_reset_out", 32'({out, outx}), 32'h0);
    chk("midstall_reset_ctrl", 32'(ctrl), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gigatron_core_ext.md
Name: gigatron_core_ext

Overview:
Parametrised successor to the Gigatron CPU core. It executes the same 8-bit Harvard instruction set with one-stage fetch and a branch delay slot, over the same op/mode/bus decode. It adds a generic upper-half RAM bank mapper and fetch/data wait-state handshakes, so slow ROM/SDRAM can sit behind it. It sits between the board ROM/RAM controllers and the VGA/IO glue in the top level.

Parameters:
PC_W, 16, program counter / ROM address width (≥9).
BANK_W, 2, RAM bank-select bits taken from ctrl[7:8-BANK_W]; 0 disables banking.
RESET_PC, 0, PC value loaded on reset.

Ports:
clock  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
pc  out  PC_W  ROM fetch address
rom_i  in  16  instruction word for pc
rom_ready  in  1  rom_i valid this cycle
addr_r  out  15+BANK_W  physical RAM read address (combinational)
mem_ready  in  1  data_i valid this cycle
data_i  in  8  RAM read data
addr_w  out  15+BANK_W  physical RAM write address (registered)
data_o  out  8  RAM write data
we  out  1  one-cycle write strobe
inreg  in  8  input port (bus=3)
out  out  8  output port
outx  out  8  extended output latch
ctrl  out  8  control register (SPI, bank bits)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, ir=16'h0200 (NOP: ld ac,ac), ac=x=y=0, out=outx=ctrl=0, we=0, addr_w=0, data_o=0. Release is synchronised by the caller.
- Decode: op=ir[15:13], mode=ir[12:10], bus=ir[9:8], d=ir[7:0]. Bus 0=d, 1=data_i, 2=ac, 3=inreg.
- ALU: 8-bit, carries discarded. Operations: LD, AND, OR, XOR, ADD, SUB (ac−b, mod 256).
- Logical address:
  - branch: d.
  - other ops by mode: 0/4/5/6=d, 1=x, 2={y,d}, 3/7={y,x}.
- Bank map:
  - logical bit15=0 → physical {0,a[14:0]}.
  - bit15=1 → {bank,a[14:0]}, where bank=ctrl bank field, and field value 0 maps to bank 1.
  - BANK_W=0: physical = a[14:0].
- Stall: stall = !rom_ready | (needs_read & !mem_ready), with needs_read = (op≠6 & bus==1).
  - While stalled: pc, ir, ac, x, y, out, outx, ctrl hold; we=0.
  - Stall has no length limit.
- Execute (no stall): ir←rom_i, pc←pc+1 (wraps at 2^PC_W), we←0, then per op:
  - store (op 6): addr_w←physical addr, data_o←b, we←(bus≠1). mode4 x←b, mode5 y←b, mode7 x←x+1. bus==1 → ctrl←d, no RAM write.
  - branch (op 7): cond from zac={~ac[7],ac[6:0]} vs 8'h80. Modes: 0 JMP (always, high byte=y), 1 GT, 2 LT, 3 NE, 4 EQ, 5 GE, 6 LE, 7 BRA (always). Taken → pc←{hi,b}, hi=y for mode0 else pc[PC_W-1:8]. The next-fetched instruction (delay slot) always executes.
  - ALU (op 0-5):
    - mode0-3 → ac.
    - mode4 → x.
    - mode5 → y.
    - mode6/7 → out←alu; mode7 & bus==1 also x←x+1.
    - If out[6]==0 and alu[6]==1, outx←ac (HSYNC rising edge), same cycle.
- Simultaneous cases:
  - x++ and a store to x cannot coincide (distinct modes).
  - mode7 store addresses with the pre-increment x.
- Reset mid-stall: all state reset; no pending write survives.

Optional Feature:
GIGATRON_DEBUG_EN
- Defined: adds ports halt (in 1) and step (in 1, one-cycle pulse), plus a two-state FSM RUN/HALT.
  - RUN→HALT when halt=1 at an instruction boundary (no stall).
  - In HALT the core behaves as stalled; step=1 executes exactly one instruction, then returns to HALT.
  - HALT→RUN when halt=0.
  - Reset state: RUN.
- Undefined: no halt/step ports and no FSM; the core runs whenever not stalled.

Decomposition:
Package gigatron_pkg holds:
- op/mode/bus enumerations
- the NOP constant 16'h0200
- the zac bias constant 8'h80
- the bank-0 alias constant

One sub-module, gigatron_alu: combinational bus mux, ALU and branch condition, shared with future cores.

Test Plan:
1. Reset release, rom_i=16'h00AB (ld $AB) → NOP executes in the first cycle; ac=8'hAB one executed instruction after.
2. ac=8'h05 then `bne $10` followed by `ld $77` → pc high byte kept, low byte=8'h10; ac=8'h77 via the delay slot.
3. ctrl=8'h00, store to logical 16'h8123 → addr_w={bank 1,15'h0123}. ctrl=8'hC0 (BANK_W=2) → bank 3.
4. ld [x] with mem_ready low for 3 cycles, data_i=8'h5A → pc and ac frozen 3 cycles, we=0; ac=8'h5A after mem_ready.
5. out=8'h00, ac=8'h40, `ld ac,out` → out=8'h40, outx=8'h40. Repeating it leaves outx unchanged.
6. (GIGATRON_DEBUG_EN) halt=1, then two step pulses → pc advances exactly 2; halt=0 resumes free running.
